break_fetch_sequencer: RTL

Upstream feeder of the break counter/selector stage in the WalkSAT flip pipeline. It takes the NSAT variable IDs of the chosen unsatisfied clause, issues one pipelined read per valid literal to the per-variable break/mask table, and streams the returned MC-bit broken-clause and mask words into the selector, one slot per cycle. It also drives the selector's write index and per-slot valid bits, and signals completion so the flip controller can sample `select_o`.

---
 rtl/break_fetch_sequencer.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/break_fetch_sequencer.sv
// break_fetch_sequencer
//
// Feeds the WalkSAT break counter/selector. For the chosen unsatisfied clause
// it reads the break/mask table once per valid literal (ascending slot order,
// one read per cycle), then forwards each in-order response to the selector
// as a slot write one cycle after it arrives. done_o pulses once the final
// slot has been written.
//
// Optional feature macro: BREAK_FETCH_TIMEOUT_EN
//   defined   : response watchdog of TIMEOUT_CYCLES; on expiry error_o pulses,
//               the fetch is abandoned (no done_o) and stray responses dropped
//   undefined : no watchdog; error_o is constant 0
//
// Ports
//   clk, reset             clock (rising edge), async active-high reset
//   start_i                launch a fetch (ignored unless idle and not busy)
//   clause_vars_i          NSAT variable IDs, slot k at [k*VAR_BITS +: VAR_BITS]
//   clause_lits_valid_i    per-slot literal-present bits
//   rd_en_o, rd_addr_o     table read strobe / variable ID
//   rd_data_valid_i        in-order table response strobe
//   rd_break_i, rd_mask_i  response words (MC bits each)
//   clause_broken_o        to selector clause_broken_i
//   mask_bits_o            to selector mask_bits_i
//   wren_o                 0 = no write, k+1 = write slot k
//   break_values_valid_o   latched copy of clause_lits_valid_i
//   busy_o                 accept .. one cycle after done_o (or abort)
//   done_o                 one-cycle pulse after the final slot write
//   error_o                one-cycle watchdog pulse
//
// state  | meaning
// IDLE   | waiting for start_i
// ISSUE  | one table read per cycle for the remaining valid slots
// WAIT   | all reads issued, collecting outstanding responses
// DONE   | every response written; done_o pulses on exit

module break_fetch_sequencer #(
  parameter int MAX_CLAUSES_PER_VARIABLE = 20,
  parameter int NSAT                     = 3,
  parameter int NSAT_BITS                = 2,
  parameter int VAR_BITS                 = 16
`ifdef BREAK_FETCH_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES         = 64
`endif
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start_i,
  input  logic [NSAT*VAR_BITS-1:0]            clause_vars_i,
  input  logic [NSAT-1:0]                     clause_lits_valid_i,
  output logic                                rd_en_o,
  output logic [VAR_BITS-1:0]                 rd_addr_o,
  input  logic                                rd_data_valid_i,
  input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] rd_break_i,
  input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] rd_mask_i,
  output logic [MAX_CLAUSES_PER_VARIABLE-1:0] clause_broken_o,
  output logic [MAX_CLAUSES_PER_VARIABLE-1:0] mask_bits_o,
  output logic [NSAT_BITS-1:0]                wren_o,
  output logic [NSAT-1:0]                     break_values_valid_o,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                error_o
);

  localparam int MC = MAX_CLAUSES_PER_VARIABLE;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t state_q, state_d;

  // Latched clause and the ordered slot list. slot_q is the slot-index FIFO:
  // issue_cnt_q is its read-issue pointer, resp_cnt_q its pop (head) pointer.
  logic [NSAT*VAR_BITS-1:0] vars_q, vars_d;
  logic [NSAT_BITS-1:0]     slot_q [NSAT];
  logic [NSAT_BITS-1:0]     slot_d [NSAT];
  logic [NSAT_BITS-1:0]     n_q, n_d;
  logic [NSAT_BITS-1:0]     issue_cnt_q, issue_d;
  logic [NSAT_BITS-1:0]     resp_cnt_q, resp_d;

  logic                     rd_en_d;
  logic [VAR_BITS-1:0]      rd_addr_d;
  logic [MC-1:0]            broken_d, mask_d;
  logic [NSAT_BITS-1:0]     wren_d;
  logic [NSAT-1:0]          bvv_d;
  logic                     busy_d, done_d, error_d;

  logic [NSAT_BITS-1:0]     list_slot [NSAT];
  logic [NSAT_BITS-1:0]     list_cnt;
  logic                     accept, resp_fire, all_issued, timeout_hit;
  logic [NSAT_BITS-1:0]     resp_next;

  // Compact the valid slots of the incoming clause into ascending order.
  always_comb begin
    list_cnt = '0;
    for (int k = 0; k < NSAT; k++) list_slot[k] = '0;
    for (int k = 0; k < NSAT; k++) begin
      if (clause_lits_valid_i[k]) begin
        list_slot[list_cnt] = NSAT_BITS'(k);
        list_cnt            = list_cnt + NSAT_BITS'(1);
      end
    end
  end

  // busy_o stays high for the done_o cycle, so gating on it keeps a start in
  // that cycle from being taken.
  assign accept     = (state_q == S_IDLE) && start_i && !busy_o;
  assign resp_fire  = rd_data_valid_i && ((state_q == S_ISSUE) || (state_q == S_WAIT))
                      && (resp_cnt_q < issue_cnt_q);
  assign resp_next  = resp_fire ? resp_cnt_q + NSAT_BITS'(1) : resp_cnt_q;
  assign all_issued = (issue_cnt_q == n_q);

`ifdef BREAK_FETCH_TIMEOUT_EN
  localparam int TMO_BITS = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_BITS-1:0] tmo_cnt_q;

  // WAIT always has at least one read outstanding; the count restarts on
  // every response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_q <= '0;
    end else if ((state_q != S_WAIT) || resp_fire) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + TMO_BITS'(1);
    end
  end

  assign timeout_hit = (state_q == S_WAIT) && !resp_fire
                       && (tmo_cnt_q == TMO_BITS'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (list_cnt == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (all_issued) state_d = (resp_next == n_q) ? S_DONE : S_WAIT;
      S_WAIT: begin
        if (timeout_hit)            state_d = S_IDLE;
        else if (resp_next == n_q)  state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values (all outputs are registered below)
  always_comb begin
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_o;
    wren_d    = '0;
    broken_d  = clause_broken_o;
    mask_d    = mask_bits_o;
    bvv_d     = break_values_valid_o;
    busy_d    = busy_o;
    done_d    = 1'b0;
    error_d   = timeout_hit;
    vars_d    = vars_q;
    n_d       = n_q;
    issue_d   = issue_cnt_q;
    resp_d    = resp_next;
    for (int k = 0; k < NSAT; k++) slot_d[k] = slot_q[k];

    case (state_q)
      S_IDLE: begin
        if (done_o) busy_d = 1'b0;
        if (accept) begin
          busy_d  = 1'b1;
          bvv_d   = clause_lits_valid_i;
          vars_d  = clause_vars_i;
          n_d     = list_cnt;
          resp_d  = '0;
          issue_d = '0;
          for (int k = 0; k < NSAT; k++) slot_d[k] = list_slot[k];
          // The first read goes out straight from the accept edge.
          if (list_cnt != '0) begin
            rd_en_d   = 1'b1;
            rd_addr_d = clause_vars_i[list_slot[0]*VAR_BITS +: VAR_BITS];
            issue_d   = NSAT_BITS'(1);
          end
        end
      end
      S_ISSUE: begin
        if (!all_issued) begin
          rd_en_d   = 1'b1;
          rd_addr_d = vars_q[slot_q[issue_cnt_q]*VAR_BITS +: VAR_BITS];
          issue_d   = issue_cnt_q + NSAT_BITS'(1);
        end
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase

    if (resp_fire) begin
      wren_d   = slot_q[resp_cnt_q] + NSAT_BITS'(1);
      broken_d = rd_break_i;
      mask_d   = rd_mask_i;
    end

    if (timeout_hit) begin
      busy_d  = 1'b0;
      n_d     = '0;
      issue_d = '0;
      resp_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_en_o              <= 1'b0;
      rd_addr_o            <= '0;
      wren_o               <= '0;
      clause_broken_o      <= '0;
      mask_bits_o          <= '0;
      break_values_valid_o <= '0;
      busy_o               <= 1'b0;
      done_o               <= 1'b0;
      error_o              <= 1'b0;
      vars_q               <= '0;
      n_q                  <= '0;
      issue_cnt_q          <= '0;
      resp_cnt_q           <= '0;
      for (int k = 0; k < NSAT; k++) slot_q[k] <= '0;
    end else begin
      rd_en_o              <= rd_en_d;
      rd_addr_o            <= rd_addr_d;
      wren_o               <= wren_d;
      clause_broken_o      <= broken_d;
      mask_bits_o          <= mask_d;
      break_values_valid_o <= bvv_d;
      busy_o               <= busy_d;
      done_o               <= done_d;
      error_o              <= error_d;
      vars_q               <= vars_d;
      n_q                  <= n_d;
      issue_cnt_q          <= issue_d;
      resp_cnt_q           <= resp_d;
      for (int k = 0; k < NSAT; k++) slot_q[k] <= slot_d[k];
    end
  end

endmodule
